// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC default,
// fault codes (also consumed by IDU/trap logic) and an alignment helper.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUSERR   = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // A fetch address is usable only when it is word aligned.
    function automatic logic pc_is_aligned(input logic [1:0] pc_lo);
        return (pc_lo == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, issues one imem read per
// instruction over valid/ready, presents the word plus PC (and a fault code) to
// the IDU, and waits for the WBU to return the next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_NPC   = 3'd4
    } state_e;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cnt_q, cnt_d;
    logic        aligned_s;
    logic        timeout_s;
    logic        req_valid_s;
    logic        inst_valid_s;

    assign aligned_s = pc_is_aligned(pc_q[1:0]);
    assign timeout_s = (timer_q == TIMEOUT_LAST);

    // State register; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (!aligned_s) begin
                    state_d = S_OUT;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid || timeout_s) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    state_d = next_pc_valid ? S_FETCH : S_NPC;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_NPC: begin
                if (next_pc_valid) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_NPC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valids are decoded from registered state only (no inst_ready path to imem).
    always_comb begin
        req_valid_s  = 1'b0;
        inst_valid_s = 1'b0;
        case (state_q)
            S_FETCH: req_valid_s  = aligned_s;
            S_OUT:   inst_valid_s = 1'b1;
            default: begin
                req_valid_s  = 1'b0;
                inst_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture result/fault, run timer, count handshakes, load PC.
    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_FETCH: begin
                timer_d = 32'd0;
                if (!aligned_s) begin
                    inst_d    = 32'd0;
                    inst_pc_d = pc_q;
                    fault_d   = FAULT_MISALIGN;
                end else begin
                    inst_d = inst_q;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 32'd1;
                if (imem_resp_valid) begin
                    inst_pc_d = pc_q;
                    inst_d    = imem_resp_err ? 32'd0 : imem_resp_data;
                    fault_d   = imem_resp_err ? FAULT_BUSERR : FAULT_NONE;
                end else if (timeout_s) begin
                    inst_pc_d = pc_q;
                    inst_d    = 32'd0;
                    fault_d   = FAULT_TIMEOUT;
                end else begin
                    inst_d = inst_q;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    cnt_d = cnt_q + 32'd1;
                    pc_d  = next_pc_valid ? next_pc : pc_q;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_NPC: begin
                if (next_pc_valid) begin
                    pc_d = next_pc;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            fault_q   <= FAULT_NONE;
            timer_q   <= 32'd0;
            cnt_q     <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = inst_valid_s;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = fault_q;
    assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a table of fetch vectors plus hand-written
// sequences for stall, timeout, response-on-timeout-cycle and reset mid-wait.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic [31:0] fetch_cnt;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .next_pc_valid(next_pc_valid), .next_pc(next_pc), .fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
        logic        via_npc;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t        vecs[6];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Complete the handshake in S_OUT, optionally supplying the next PC together.
    task automatic handshake(input logic with_pc, input logic [31:0] pc);
        inst_ready    = 1'b1;
        next_pc_valid = with_pc;
        next_pc       = pc;
        tick();
        inst_ready    = 1'b0;
        next_pc_valid = 1'b0;
        exp_cnt       = exp_cnt + 32'd1;
        chk("fetch_cnt", fetch_cnt, exp_cnt);
        chk("valid_after_hs", 32'(inst_valid), 32'd0);
    endtask

    // Zero-wait request/response: enter S_FETCH already, ready now, response next cycle.
    task automatic mem_fetch(input logic [31:0] pc, input logic [31:0] data, input logic err);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, pc);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_inst_valid", 32'(inst_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
    endtask

    initial begin
        logic [31:0] nxt;
        logic [31:0] held_inst;
        logic [31:0] held_pc;

        vecs[0] = '{32'h8000_0000, 32'h0010_0073, 1'b0, 1'b0, 32'h0010_0073, 2'b00};
        vecs[1] = '{32'h8000_0004, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 2'b10};
        vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2'b01};
        vecs[3] = '{32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2'b01};
        vecs[5] = '{32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'b00};

        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0; imem_resp_err = 1'b0; inst_ready = 1'b0;
        next_pc_valid = 1'b0; next_pc = 32'd0; exp_cnt = 32'd0;

        tick(); tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fault", 32'(inst_fault), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);

        rst = 1'b0;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        tick();

        for (int i = 0; i < 6; i++) begin
            nxt = (i < 5) ? vecs[i + 1].pc : 32'h8000_0020;
            if (vecs[i].exp_fault == 2'b01) begin
                chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
                tick();
            end else begin
                mem_fetch(vecs[i].pc, vecs[i].data, vecs[i].err);
            end
            chk("vec_inst_valid", 32'(inst_valid), 32'd1);
            chk("vec_inst", inst, vecs[i].exp_inst);
            chk("vec_inst_pc", inst_pc, vecs[i].pc);
            chk("vec_fault", 32'(inst_fault), 32'(vecs[i].exp_fault));
            if (i == 0) begin
                held_inst     = inst;
                held_pc       = inst_pc;
                next_pc_valid = 1'b1;
                next_pc       = 32'h0000_0040;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_inst", inst, held_inst);
                    chk("stall_inst_pc", inst_pc, held_pc);
                    chk("stall_valid", 32'(inst_valid), 32'd1);
                    chk("stall_no_req", 32'(imem_req_valid), 32'd0);
                end
                next_pc_valid = 1'b0;
            end
            handshake(!vecs[i].via_npc, nxt);
            if (vecs[i].via_npc) begin
                chk("npc_no_req", 32'(imem_req_valid), 32'd0);
                tick();
                chk("npc_still_no_req", 32'(imem_req_valid), 32'd0);
                next_pc_valid = 1'b1;
                next_pc       = nxt;
                tick();
                next_pc_valid = 1'b0;
            end
        end

        // Timeout: 16 S_WAIT cycles with no response, then a late response is ignored.
        chk("to_req_addr", imem_req_addr, 32'h8000_0020);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int s = 0; s < 15; s++) tick();
        chk("to_not_yet", 32'(inst_valid), 32'd0);
        tick();
        chk("to_valid", 32'(inst_valid), 32'd1);
        chk("to_fault", 32'(inst_fault), 32'd3);
        chk("to_inst", inst, 32'd0);
        chk("to_inst_pc", inst_pc, 32'h8000_0020);
        tick(); tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h5A5A_5A5A;
        tick();
        imem_resp_valid = 1'b0;
        chk("late_resp_inst", inst, 32'd0);
        chk("late_resp_fault", 32'(inst_fault), 32'd3);
        handshake(1'b1, 32'h8000_0030);

        // Response on the final timeout cycle wins.
        chk("edge_req_addr", imem_req_addr, 32'h8000_0030);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int s = 0; s < 15; s++) tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hAAAA_5555;
        tick();
        imem_resp_valid = 1'b0;
        chk("edge_valid", 32'(inst_valid), 32'd1);
        chk("edge_fault", 32'(inst_fault), 32'd0);
        chk("edge_inst", inst, 32'hAAAA_5555);
        handshake(1'b1, 32'h8000_0040);

        // Reset while waiting; response arriving afterwards is dropped.
        chk("rw_req_addr", imem_req_addr, 32'h8000_0040);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        tick();
        imem_resp_valid = 1'b0;
        exp_cnt = 32'd0;
        chk("rw_fetch_cnt", fetch_cnt, 32'd0);
        chk("rw_inst_valid", 32'(inst_valid), 32'd0);
        chk("rw_inst", inst, 32'd0);
        mem_fetch(32'h8000_0000, 32'h2222_2222, 1'b0);
        chk("rw_new_inst", inst, 32'h2222_2222);
        chk("rw_new_pc", inst_pc, 32'h8000_0000);
        handshake(1'b1, 32'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
